// File: rtl/posit_defines.sv
// posit_defines: shared posit word width, special encodings and scheduler state type.
package posit_defines;
    localparam int NBITS = 32;
    localparam logic [NBITS-1:0] POSIT_ZERO = '0;
    localparam logic [NBITS-1:0] POSIT_NAR = {1'b1, {(NBITS-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} accum_sched_state_t;
endpackage

// File: rtl/posit_rr_arbiter.sv
// posit_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module posit_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan farthest offset first so the nearest valid requester wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + i) % NREQ);
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/posit_accum_sched.sv
// posit_accum_sched: round-robin burst scheduler feeding one posit accumulator.
// Optional POSIT_ZERO_SKIP_EN drops non-final zero words instead of forwarding them.
module posit_accum_sched
    import posit_defines::*;
#(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][NBITS-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            req_done,
    output logic                       acc_valid,
    output logic [NBITS-1:0]           acc_data,
    output logic                       acc_first,
    output logic                       acc_last,
    output logic [IW-1:0]              acc_id,
    input  logic                       acc_ready,
    input  logic                       acc_done
);
    accum_sched_state_t state, state_next;
    logic [IW-1:0]    gnt, rr_ptr, arb_idx;
    logic [NREQ-1:0]  gnt_oh, arb_grant;
    logic             arb_any, first_pend, slot_free, accept, fwd, cur_last;
    logic [NBITS-1:0] cur_data;

    posit_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign cur_data  = req_data[gnt];
    assign cur_last  = req_last[gnt];
    assign slot_free = ~acc_valid | acc_ready;
    assign req_ready = (state == BURST && slot_free) ? gnt_oh : '0;
    assign accept    = state == BURST && slot_free && req_valid[gnt];
`ifdef POSIT_ZERO_SKIP_EN
    assign fwd = accept && !(cur_data == POSIT_ZERO && !cur_last);
`else
    assign fwd = accept;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = arb_any ? BURST : IDLE;
            BURST:   state_next = (accept && cur_last) ? DRAIN : BURST;
            DRAIN:   state_next = acc_done ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_oh     <= '0;
            rr_ptr     <= '0;
            first_pend <= 1'b0;
            req_done   <= '0;
            acc_valid  <= 1'b0;
            acc_data   <= '0;
            acc_first  <= 1'b0;
            acc_last   <= 1'b0;
            acc_id     <= '0;
        end else begin
            state    <= state_next;
            req_done <= (state == DRAIN && acc_done) ? gnt_oh : '0;
            if (state == IDLE && arb_any) begin
                gnt        <= arb_idx;
                gnt_oh     <= arb_grant;
                rr_ptr     <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                first_pend <= 1'b1;
            end
            if (fwd) begin
                acc_valid  <= 1'b1;
                acc_data   <= cur_data;
                acc_first  <= first_pend;
                acc_last   <= cur_last;
                acc_id     <= gnt;
                first_pend <= 1'b0;
            end else if (acc_ready) begin
                acc_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/posit_accum_sched.md
# posit_accum_sched

Round-robin scheduler that shares one posit extract/accumulate pipeline among NREQ requesters, e.g. PairHMM processing elements that each produce a burst of posit terms to be summed. It grants the pipeline to one requester for a whole burst, delimited by a last flag. It forwards the burst words with first/last markers, waits for the accumulator's completion pulse, then returns a per-requester done pulse. Sits between the PE result streams and the posit accumulator front end.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- NBITS, from posit_defines (32), posit word width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ×NBITS  per-requester posit word
- req_last  in  NREQ  marks final word of a burst
- req_ready  out  NREQ  per-requester word accepted
- req_done  out  NREQ  one-cycle pulse: requester's burst fully accumulated
- acc_valid  out  1  word to accumulator valid
- acc_data  out  NBITS  posit word
- acc_first  out  1  first forwarded word of burst
- acc_last  out  1  final word of burst
- acc_id  out  $clog2(NREQ)  owning requester index
- acc_ready  in  1  accumulator accepts word
- acc_done  in  1  one-cycle pulse: accumulator finished current burst

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE: if any req_valid, pick the first set bit at or after rr_ptr, wrapping. Register it as gnt, set rr_ptr <= (gnt+1) mod NREQ, go to BURST. If none valid, stay.
- BURST: req_ready[gnt] = (~acc_valid | acc_ready); all other req_ready are 0. Each accepted word loads the output register: acc_data, acc_last=req_last[gnt], acc_id=gnt. acc_first is 1 on the first forwarded word of the burst only.
- The accepted word with req_last=1 moves the FSM to DRAIN.
- DRAIN: req_ready all 0. The output register empties normally. On acc_done, pulse req_done[gnt] and go to IDLE.
- acc_done outside DRAIN is ignored.
- A requester that stalls (req_valid low) in BURST keeps the grant. There is no preemption.
- acc_data is forwarded unmodified. Zero (all bits 0) and NaR (MSB only) are ordinary words unless POSIT_ZERO_SKIP_EN is defined.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt 0, acc_valid 0, acc_data 0, acc_first 0, acc_last 0, acc_id 0, req_done 0, req_ready 0.
- Grant latency: req_valid seen in IDLE at cycle t; BURST at t+1; first req_ready at t+1.
- Data latency: word accepted at t appears on acc_valid at t+1. The register holds while acc_valid & ~acc_ready.
- Throughput is 1 word/cycle when acc_ready is held high.
- acc_done at cycle t: req_done[gnt] high at t+1 and state IDLE at t+1. The next burst's first word is accepted no earlier than t+2.
- acc_done and the last-word handshake in the same cycle while in BURST: acc_done is ignored and the FSM enters DRAIN.
- Deasserting reset_n mid-burst returns all state and outputs to reset values immediately. The partial burst is discarded.

## Configuration
- POSIT_ZERO_SKIP_EN defined: an accepted word equal to zero with req_last=0 is consumed (req_ready high) but not forwarded. acc_first moves to the next forwarded word. A zero with req_last=1 is always forwarded, carrying acc_first if nothing preceded it.
- POSIT_ZERO_SKIP_EN undefined: every accepted word is forwarded.

## Structure
- posit_defines gains: accum_sched_state_t enum {IDLE, BURST, DRAIN} and a POSIT_ZERO constant. NBITS comes from the existing package.
- One sub-module: posit_rr_arbiter (NREQ request vector plus pointer in; one-hot grant, index and any-valid out; combinational).

## Test plan
- Single burst: requester 1 sends 0x40000000, 0x38000000 (last) with acc_ready=1 → acc words at consecutive cycles with acc_first=1/0, acc_last=0/1, acc_id=1. acc_done → req_done=0b0010 one cycle later.
- Round robin: requesters 0, 2 and 3 valid continuously with 1-word bursts → grant order 0,2,3,0. rr_ptr wraps after 3.
- Backpressure: acc_ready low for 5 cycles mid-burst → acc_data stable, req_ready[gnt]=0 throughout, no word lost or duplicated.
- Zero skip (macro on): words 0x00000000, 0x40000000, 0x00000000 (last) → 2 forwarded words: 0x40000000 (first) and 0x00000000 (last). Macro off → 3 words.
- Reset mid-burst: reset_n low after 2 of 4 words → all outputs 0. After release, a fresh request from requester 0 is granted first (rr_ptr=0).
- Spurious acc_done in IDLE or BURST → no req_done pulse and no state change.
